aer_roc_decoder: RTL and testbench

- AER responder and rank-order-code (ROC) decoder: receives pixel-index events over the 10-bit four-phase REQ/ACK link and reconstructs a pixel image.
- The Nth unique pixel address received gets rank N-1; its pixel value is PIXEL_MAX_VALUE minus rank, saturating at 0.
- Sits at the receive end of the input AER link (stand-alone or loopback checker for the encoder/aer_in path); provides a per-event stream plus a full reconstructed image.

---
 rtl/snn_aer_pkg.sv | 10 +
 rtl/aer_rx_handshake.sv | 47 ++++
 rtl/aer_roc_decoder.sv | 114 +++++++++++
 tb/tb_aer_roc_decoder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/snn_aer_pkg.sv
// snn_aer_pkg: shared AER link constants, receiver FSM states and the rank-order pixel mapping
package snn_aer_pkg;
    localparam int AER_ADDR_W = 10;

    typedef enum logic {RX_IDLE, RX_ACK} aer_rx_state_t;

    function automatic logic [31:0] roc_rank_to_value(input logic [31:0] rank, input logic [31:0] max_value);
        return (rank >= max_value) ? 32'd0 : max_value - rank;
    endfunction
endpackage

// File: rtl/aer_rx_handshake.sv
// aer_rx_handshake: four-phase AER responder with REQ synchronizer, emitting a capture strobe and address
module aer_rx_handshake
    import snn_aer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [AER_ADDR_W-1:0] aer_addr,
    input  logic                  aer_req,
    output logic                  aer_ack,
    output logic                  cap_stb,
    output logic [AER_ADDR_W-1:0] cap_addr
);
    logic [1:0]            sync_q;
    aer_rx_state_t         state_q, state_d;
    logic [AER_ADDR_W-1:0] addr_q, addr_d;
    logic                  req_s;

    assign req_s    = sync_q[1];
    assign aer_ack  = state_q == RX_ACK;
    assign cap_addr = addr_d;

    // The address is taken straight from the link: it is stable once req_s is seen high.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cap_stb = 1'b0;
        if (state_q == RX_IDLE && req_s) begin
            state_d = RX_ACK;
            addr_d  = aer_addr;
            cap_stb = 1'b1;
        end else if (state_q == RX_ACK && !req_s) begin
            state_d = RX_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= RX_IDLE;
            addr_q  <= '0;
        end else begin
            sync_q  <= {sync_q[0], aer_req};
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end
endmodule

// File: rtl/aer_roc_decoder.sv
// aer_roc_decoder: AER receiver that rebuilds a rank-order-coded image from unique pixel events
module aer_roc_decoder
    import snn_aer_pkg::*;
#(
    parameter int IMAGE_SIZE      = 256,
    parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int PIXEL_MAX_VALUE = 255,
    parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE)
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [AER_ADDR_W-1:0]      AERIN_ADDR,
    input  logic                       AERIN_REQ,
    output logic                       AERIN_ACK,
    input  logic                       NEW_FRAME,
    output logic                       EVT_VALID,
    output logic [IMAGE_SIZE_BITS-1:0] EVT_ADDR,
    output logic [IMAGE_SIZE_BITS-1:0] EVT_RANK,
    output logic [PIXEL_BITS-1:0]      IMAGE_OUT [0:IMAGE_SIZE-1],
    output logic                       DECODE_DONE,
    output logic                       ERR_RANGE,
    output logic                       ERR_DUP,
    output logic                       ERR_OVF
);
    localparam int RW = IMAGE_SIZE_BITS + 1;

    logic                       cap_stb;
    logic [AER_ADDR_W-1:0]      cap_addr;
    logic [IMAGE_SIZE_BITS-1:0] idx;
    logic                       in_range;
    logic [RW-1:0]              rank_q, rank_d, rank_b;
    logic [PIXEL_BITS-1:0]      pix;
    logic [IMAGE_SIZE-1:0]      seen_q, seen_d;
    logic [PIXEL_BITS-1:0]      img_q [0:IMAGE_SIZE-1];
    logic [PIXEL_BITS-1:0]      img_d [0:IMAGE_SIZE-1];
    logic                       err_range_q, err_range_d, err_dup_q, err_dup_d, err_ovf_q, err_ovf_d;
    logic                       evt_valid_q, evt_valid_d;
    logic [IMAGE_SIZE_BITS-1:0] evt_addr_q, evt_addr_d, evt_rank_q, evt_rank_d;

    aer_rx_handshake u_rx (
        .clk      (CLK),
        .rst_n    (RST_N),
        .aer_addr (AERIN_ADDR),
        .aer_req  (AERIN_REQ),
        .aer_ack  (AERIN_ACK),
        .cap_stb  (cap_stb),
        .cap_addr (cap_addr)
    );

    assign idx      = cap_addr[IMAGE_SIZE_BITS-1:0];
    assign in_range = 32'(cap_addr) < IMAGE_SIZE;
    // A coinciding NEW_FRAME clears first, so the event is ranked against the empty frame.
    assign rank_b   = NEW_FRAME ? '0 : rank_q;
    assign pix      = PIXEL_BITS'(roc_rank_to_value(32'(rank_b), 32'(PIXEL_MAX_VALUE)));

    always_comb begin
        seen_d      = NEW_FRAME ? '0 : seen_q;
        rank_d      = rank_b;
        err_range_d = !NEW_FRAME && err_range_q;
        err_dup_d   = !NEW_FRAME && err_dup_q;
        err_ovf_d   = !NEW_FRAME && err_ovf_q;
        evt_valid_d = 1'b0;
        evt_addr_d  = evt_addr_q;
        evt_rank_d  = evt_rank_q;
        for (int i = 0; i < IMAGE_SIZE; i++) img_d[i] = NEW_FRAME ? '0 : img_q[i];
        // A full frame has seen every address, so overflow is reported ahead of duplicate.
        if (cap_stb) begin
            if (!in_range) err_range_d = 1'b1;
            else if (rank_b == RW'(IMAGE_SIZE)) err_ovf_d = 1'b1;
            else if (seen_d[idx]) err_dup_d = 1'b1;
            else begin
                evt_valid_d = 1'b1;
                evt_addr_d  = idx;
                evt_rank_d  = rank_b[IMAGE_SIZE_BITS-1:0];
                img_d[idx]  = pix;
                seen_d[idx] = 1'b1;
                rank_d      = rank_b + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rank_q      <= '0;
            seen_q      <= '0;
            img_q       <= '{default: '0};
            err_range_q <= 1'b0;
            err_dup_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_addr_q  <= '0;
            evt_rank_q  <= '0;
        end else begin
            rank_q      <= rank_d;
            seen_q      <= seen_d;
            img_q       <= img_d;
            err_range_q <= err_range_d;
            err_dup_q   <= err_dup_d;
            err_ovf_q   <= err_ovf_d;
            evt_valid_q <= evt_valid_d;
            evt_addr_q  <= evt_addr_d;
            evt_rank_q  <= evt_rank_d;
        end
    end

    assign IMAGE_OUT   = img_q;
    assign DECODE_DONE = rank_q == RW'(IMAGE_SIZE);
    assign ERR_RANGE   = err_range_q;
    assign ERR_DUP     = err_dup_q;
    assign ERR_OVF     = err_ovf_q;
    assign EVT_VALID   = evt_valid_q;
    assign EVT_ADDR    = evt_addr_q;
    assign EVT_RANK    = evt_rank_q;
endmodule

// File: tb/tb_aer_roc_decoder.sv
// tb_aer_roc_decoder: directed AER events checked every cycle against a frame-level decoder model
module tb_aer_roc_decoder;
    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [9:0] AERIN_ADDR = '0;
    logic       AERIN_REQ = 1'b0;
    logic       AERIN_ACK;
    logic       NEW_FRAME = 1'b0;
    logic       EVT_VALID;
    logic [7:0] EVT_ADDR, EVT_RANK;
    logic [7:0] IMAGE_OUT [0:255];
    logic       DECODE_DONE, ERR_RANGE, ERR_DUP, ERR_OVF;

    int n_cmp = 0, n_err = 0;

    aer_roc_decoder dut (
        .CLK(CLK), .RST_N(RST_N), .AERIN_ADDR(AERIN_ADDR), .AERIN_REQ(AERIN_REQ),
        .AERIN_ACK(AERIN_ACK), .NEW_FRAME(NEW_FRAME), .EVT_VALID(EVT_VALID),
        .EVT_ADDR(EVT_ADDR), .EVT_RANK(EVT_RANK), .IMAGE_OUT(IMAGE_OUT),
        .DECODE_DONE(DECODE_DONE), .ERR_RANGE(ERR_RANGE), .ERR_DUP(ERR_DUP), .ERR_OVF(ERR_OVF)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame model: one entry per pixel, rank = number of unique accepted events so far.
    int  m_img [0:255];
    bit  m_seen [0:255];
    int  m_rank, m_evt_addr, m_evt_rank;
    bit  m_valid, m_range, m_dup, m_ovf;

    task automatic model_clear();
        for (int i = 0; i < 256; i++) begin m_img[i] = 0; m_seen[i] = 0; end
        m_rank = 0; m_range = 0; m_dup = 0; m_ovf = 0;
    endtask

    task automatic model_event(input int a);
        if (a >= 256) m_range = 1;
        else if (m_rank == 256) m_ovf = 1;
        else if (m_seen[a]) m_dup = 1;
        else begin
            m_img[a] = (m_rank >= 255) ? 0 : 255 - m_rank;
            m_seen[a] = 1;
            m_valid = 1;
            m_evt_addr = a;
            m_evt_rank = m_rank;
            m_rank++;
        end
    endtask

    bit nf_e, ack_prev;
    int addr_e;
    always @(posedge CLK) begin
        nf_e   = NEW_FRAME;
        addr_e = int'(AERIN_ADDR);
    end

    always @(negedge CLK) begin
        int bi;
        m_valid = 0;
        if (!RST_N) begin
            model_clear();
            m_evt_addr = 0;
            m_evt_rank = 0;
            chk("ack_in_reset", int'(AERIN_ACK), 0);
        end else begin
            if (nf_e) model_clear();
            if (!ack_prev && AERIN_ACK) model_event(addr_e);
        end
        ack_prev = AERIN_ACK;
        chk("evt_valid", int'(EVT_VALID), int'(m_valid));
        chk("evt_addr", int'(EVT_ADDR), m_evt_addr);
        chk("evt_rank", int'(EVT_RANK), m_evt_rank);
        chk("decode_done", int'(DECODE_DONE), int'(m_rank == 256));
        chk("err_range", int'(ERR_RANGE), int'(m_range));
        chk("err_dup", int'(ERR_DUP), int'(m_dup));
        chk("err_ovf", int'(ERR_OVF), int'(m_ovf));
        bi = -1;
        for (int i = 0; i < 256; i++) if (bi < 0 && int'(IMAGE_OUT[i]) != m_img[i]) bi = i;
        n_cmp++;
        if (bi >= 0) begin
            n_err++;
            $display("FAIL image_out[%0d]: got %0d, expected %0d (t=%0t)", bi, IMAGE_OUT[bi], m_img[bi], $time);
        end
    end

    // Called just after a rising edge; nf_edge selects the handshake edge that carries NEW_FRAME.
    task automatic send(input int addr, input int nf_edge = 0);
        int n;
        AERIN_ADDR = 10'(addr);
        AERIN_REQ  = 1'b1;
        n = 0;
        while (!AERIN_ACK && n < 20) begin
            NEW_FRAME = (n + 1 == nf_edge);
            @(posedge CLK); #1;
            NEW_FRAME = 1'b0;
            n++;
        end
        chk("ack_rise_latency", n, 3);
        AERIN_REQ = 1'b0;
        n = 0;
        while (AERIN_ACK && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("ack_fall_latency", n, 3);
    endtask

    task automatic pulse_new_frame();
        NEW_FRAME = 1'b1;
        @(posedge CLK); #1;
        NEW_FRAME = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        chk("reset_ack", int'(AERIN_ACK), 0);
        chk("reset_done", int'(DECODE_DONE), 0);

        send(5); send(9); send(2);
        chk("lit_rank_2", int'(EVT_RANK), 2);
        chk("lit_img5", int'(IMAGE_OUT[5]), 255);
        chk("lit_img9", int'(IMAGE_OUT[9]), 254);
        chk("lit_img2", int'(IMAGE_OUT[2]), 253);
        chk("lit_img0_unset", int'(IMAGE_OUT[0]), 0);

        pulse_new_frame();
        for (int a = 255; a >= 0; a--) send(a);
        chk("lit_done", int'(DECODE_DONE), 1);
        chk("lit_img255", int'(IMAGE_OUT[255]), 255);
        chk("lit_img1", int'(IMAGE_OUT[1]), 1);
        chk("lit_img0", int'(IMAGE_OUT[0]), 0);
        chk("lit_no_err", int'({ERR_RANGE, ERR_DUP, ERR_OVF}), 0);

        send(3);
        chk("lit_ovf", int'(ERR_OVF), 1);
        chk("lit_img3_kept", int'(IMAGE_OUT[3]), 3);

        pulse_new_frame();
        chk("lit_cleared_done", int'(DECODE_DONE), 0);
        chk("lit_cleared_ovf", int'(ERR_OVF), 0);
        chk("lit_cleared_img", int'(IMAGE_OUT[255]), 0);

        send(300); send(7); send(7);
        chk("lit_range", int'(ERR_RANGE), 1);
        chk("lit_dup", int'(ERR_DUP), 1);
        chk("lit_rank_7", int'(EVT_RANK), 0);
        chk("lit_img7", int'(IMAGE_OUT[7]), 255);

        send(12, 3);
        chk("lit_nf_img12", int'(IMAGE_OUT[12]), 255);
        chk("lit_nf_img7", int'(IMAGE_OUT[7]), 0);
        chk("lit_nf_rank", int'(EVT_RANK), 0);
        chk("lit_nf_flags", int'({ERR_RANGE, ERR_DUP}), 0);
        send(13);
        chk("lit_rank_after_nf", int'(EVT_RANK), 1);
        chk("lit_img13", int'(IMAGE_OUT[13]), 254);

        AERIN_ADDR = 10'd40;
        AERIN_REQ  = 1'b1;
        n = 0;
        while (!AERIN_ACK && n < 20) begin @(posedge CLK); #1; n++; end
        chk("rst_test_ack_rise", n, 3);
        #3 RST_N = 1'b0;
        #1 chk("lit_ack_async_drop", int'(AERIN_ACK), 0);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        n = 0;
        while (!AERIN_ACK && n < 20) begin @(posedge CLK); #1; n++; end
        chk("recapture_latency", n, 3);
        AERIN_REQ = 1'b0;
        n = 0;
        while (AERIN_ACK && n < 20) begin @(posedge CLK); #1; n++; end
        chk("recapture_fall", n, 3);
        chk("lit_recap_rank", int'(EVT_RANK), 0);
        chk("lit_recap_img40", int'(IMAGE_OUT[40]), 255);
        chk("lit_recap_img12", int'(IMAGE_OUT[12]), 0);

        repeat (3) @(posedge CLK);
        #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
